// File: rtl/red_pkg.sv
// Shared definitions for the Red processor front end: default widths and the
// next-PC source encoding used by the fetch stage.
package red_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [2:0] {
    NPC_INC,
    NPC_BR,
    NPC_CALL,
    NPC_RET,
    NPC_RST
  } npc_sel_e;

  // Priority encoder for the next-PC source: reset, then ret, call, br.
  function automatic npc_sel_e npc_select(input logic rst, input logic br,
                                          input logic call, input logic ret);
    if (rst)       return NPC_RST;
    else if (ret)  return NPC_RET;
    else if (call) return NPC_CALL;
    else if (br)   return NPC_BR;
    else           return NPC_INC;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control requests from decode, the instruction ROM port and
// the registered opcode handed to decode.
interface fetch_unit_if
  import red_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              en;
  logic              stall;
  logic              br;
  logic [ADDR_W-1:0] br_target;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] opcode;
  logic [ADDR_W-1:0] op_pc;
  logic              valid;
  logic              stack_err;

  // The fetch unit itself: drives the ROM address and the decode-side outputs.
  modport master (
    input  en, stall, br, br_target, call, ret, rom_data,
    output rom_addr, opcode, op_pc, valid, stack_err
  );

  // Environment side: decode plus instruction ROM.
  modport slave (
    output en, stall, br, br_target, call, ret, rom_data,
    input  rom_addr, opcode, op_pc, valid, stack_err
  );

endinterface

// File: rtl/fetch_unit_ret_stack.sv
// Hardware return-address stack. LIFO of DEPTH entries; pop has priority over
// push, and requests that would overflow or underflow are ignored.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [2**IDX_W];
  logic [SP_W-1:0]  sp;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_idx = IDX_W'(sp);
  assign rd_idx = IDX_W'(sp - SP_W'(1));
  assign full   = (sp == SP_W'(DEPTH));
  assign empty  = (sp == '0);
  assign dout   = empty ? '0 : mem[rd_idx];

  // Stack pointer: counts occupied entries; reset empties the stack in one cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst)                 sp <= '0;
    else if (pop && !empty)  sp <= sp - SP_W'(1);
    else if (push && !full)  sp <= sp + SP_W'(1);
  end

  // Entry storage: written on an accepted push, never cleared on pop.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; sp alone defines which
    // entries are live, and an unreset array maps onto plain RAM/flops.
    if (push && !pop && !full) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Red instruction fetch stage: program counter, next-PC selection, return
// stack control and the opcode/op_pc/valid pipeline register toward decode.
module fetch_unit
  import red_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int RESET_VEC   = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] npc;
  logic [ADDR_W-1:0] op_pc_q;
  logic [DATA_W-1:0] opcode_q;
  logic              valid_q;
  logic              err_q;

  logic              advance;
  logic              redirect;
  logic              push;
  logic              pop;
  logic              stk_fault;
  logic              stk_full;
  logic              stk_empty;
  logic [ADDR_W-1:0] stk_top;
  npc_sel_e          npc_sel;

  assign advance  = !rst && bus.en && !bus.stall;
  assign npc_sel  = npc_select(rst, bus.br, bus.call, bus.ret);
  assign redirect = advance && (npc_sel inside {NPC_BR, NPC_CALL, NPC_RET});
  assign push     = advance && (npc_sel == NPC_CALL) && !stk_full;
  assign pop      = advance && (npc_sel == NPC_RET) && !stk_empty;
  assign stk_fault = advance && (((npc_sel == NPC_RET) && stk_empty) ||
                                 ((npc_sel == NPC_CALL) && stk_full));

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (op_pc_q + ADDR_W'(1)),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Next-PC mux; an underflowing return restarts at the reset vector.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves npc
    // unassigned, which would infer a latch.
    npc = pc + ADDR_W'(1);
    unique case (npc_sel)
      NPC_RET:  npc = stk_empty ? ADDR_W'(RESET_VEC) : stk_top;
      NPC_CALL: npc = bus.br_target;
      NPC_BR:   npc = bus.br_target;
      NPC_RST:  npc = ADDR_W'(RESET_VEC);
      default:  npc = pc + ADDR_W'(1);
    endcase
  end

  // Pipeline registers: advance only when enabled and not stalled; a redirect
  // turns the fall-through opcode captured this cycle into a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= ADDR_W'(RESET_VEC);
      opcode_q <= '0;
      op_pc_q  <= '0;
      valid_q  <= 1'b0;
    end else if (advance) begin
      pc       <= npc;
      opcode_q <= bus.rom_data;
      op_pc_q  <= pc;
      valid_q  <= !redirect;
    end
  end

  // Sticky stack error: set on overflow or underflow, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)            err_q <= 1'b0;
    else if (stk_fault) err_q <= 1'b1;
  end

  assign bus.rom_addr  = pc;
  assign bus.opcode    = opcode_q;
  assign bus.op_pc     = op_pc_q;
  assign bus.valid     = valid_q;
  assign bus.stack_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: free run with wrap, branch, call/return,
// return-stack overflow/underflow, stall/enable hold and reset mid-stall.
// The ROM model returns address + 0x100.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  fetch_unit_if #(.DATA_W(16), .ADDR_W(8)) bus ();

  fetch_unit #(
    .DATA_W      (16),
    .ADDR_W      (8),
    .RESET_VEC   (0),
    .STACK_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.rom_data = 16'h0100 + {8'h00, bus.rom_addr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_call(input logic [7:0] target);
    bus.call = 1'b1;
    bus.br_target = target;
    tick();
    bus.call = 1'b0;
    tick();
  endtask

  task automatic do_ret();
    bus.ret = 1'b1;
    tick();
    bus.ret = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] ret_exp [5];
    ret_exp[0] = 8'h41; ret_exp[1] = 8'h31; ret_exp[2] = 8'h21;
    ret_exp[3] = 8'h14; ret_exp[4] = 8'h00;

    rst = 1'b1;
    bus.en = 1'b1; bus.stall = 1'b0;
    bus.br = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.br_target = '0;
    tick();
    tick();

    // Reset state
    check("rst_rom_addr", bus.rom_addr, 8'h00);
    check("rst_opcode", bus.opcode, 16'h0000);
    check("rst_op_pc", bus.op_pc, 8'h00);
    check("rst_valid", bus.valid, 1'b0);
    check("rst_stack_err", bus.stack_err, 1'b0);

    // First advance edge delivers ROM[RESET_VEC]
    rst = 1'b0;
    tick();
    check("first_opcode", bus.opcode, 16'h0100);
    check("first_op_pc", bus.op_pc, 8'h00);
    check("first_valid", bus.valid, 1'b1);
    check("first_rom_addr", bus.rom_addr, 8'h01);
    tick();
    check("run_opcode", bus.opcode, 16'h0101);
    check("run_op_pc", bus.op_pc, 8'h01);

    // Free run up to the address wrap
    repeat (254) tick();
    check("top_op_pc", bus.op_pc, 8'hFF);
    check("top_opcode", bus.opcode, 16'h01FF);
    check("top_rom_addr", bus.rom_addr, 8'h00);
    tick();
    check("wrap_op_pc", bus.op_pc, 8'h00);
    check("wrap_opcode", bus.opcode, 16'h0100);
    check("wrap_valid", bus.valid, 1'b1);

    // Branch to 0x40 while op_pc = 0x05
    repeat (5) tick();
    check("pre_br_op_pc", bus.op_pc, 8'h05);
    bus.br = 1'b1; bus.br_target = 8'h40;
    tick();
    bus.br = 1'b0;
    check("br_bubble", bus.valid, 1'b0);
    check("br_rom_addr", bus.rom_addr, 8'h40);
    tick();
    check("br_opcode", bus.opcode, 16'h0140);
    check("br_op_pc", bus.op_pc, 8'h40);
    check("br_valid", bus.valid, 1'b1);

    // Call 0x80 from op_pc 0x10, then return
    bus.br = 1'b1; bus.br_target = 8'h10;
    tick();
    bus.br = 1'b0;
    tick();
    check("pre_call_op_pc", bus.op_pc, 8'h10);
    bus.call = 1'b1; bus.br_target = 8'h80;
    tick();
    bus.call = 1'b0;
    check("call_bubble", bus.valid, 1'b0);
    check("call_rom_addr", bus.rom_addr, 8'h80);
    tick();
    check("call_opcode", bus.opcode, 16'h0180);
    check("call_op_pc", bus.op_pc, 8'h80);
    tick();
    bus.ret = 1'b1;
    tick();
    bus.ret = 1'b0;
    check("ret_bubble", bus.valid, 1'b0);
    check("ret_rom_addr", bus.rom_addr, 8'h11);
    tick();
    check("ret_op_pc", bus.op_pc, 8'h11);
    check("ret_opcode", bus.opcode, 16'h0111);
    check("ret_valid", bus.valid, 1'b1);
    tick();
    tick();
    check("after_ret_op_pc", bus.op_pc, 8'h13);
    check("no_err_yet", bus.stack_err, 1'b0);

    // Five nested calls on a 4-deep stack
    for (int i = 0; i < 4; i++) begin
      do_call(8'h20 + 8'(i * 16));
      check("nest_op_pc", bus.op_pc, 32'(8'h20 + 8'(i * 16)));
    end
    check("full_no_err", bus.stack_err, 1'b0);
    do_call(8'h60);
    check("ovf_op_pc", bus.op_pc, 8'h60);
    check("ovf_opcode", bus.opcode, 16'h0160);
    check("ovf_err", bus.stack_err, 1'b1);
    for (int i = 0; i < 5; i++) begin
      do_ret();
      check("unwind_op_pc", bus.op_pc, 32'(ret_exp[i]));
      check("unwind_valid", bus.valid, 1'b1);
    end
    check("unwind_opcode", bus.opcode, 16'h0100);

    // Stall with a branch request held: everything freezes, branch ignored
    tick();
    tick();
    check("pre_stall_op_pc", bus.op_pc, 8'h02);
    bus.stall = 1'b1; bus.br = 1'b1; bus.br_target = 8'h70;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_op_pc", bus.op_pc, 8'h02);
      check("stall_opcode", bus.opcode, 16'h0102);
      check("stall_valid", bus.valid, 1'b1);
      check("stall_rom_addr", bus.rom_addr, 8'h03);
    end
    bus.stall = 1'b0; bus.br = 1'b0;
    tick();
    check("resume_op_pc", bus.op_pc, 8'h03);
    check("resume_rom_addr", bus.rom_addr, 8'h04);

    // Enable low also holds state and ignores requests
    bus.en = 1'b0; bus.br = 1'b1;
    tick();
    check("en_hold_op_pc", bus.op_pc, 8'h03);
    check("en_hold_rom_addr", bus.rom_addr, 8'h04);
    bus.en = 1'b1; bus.br = 1'b0;

    // Reset during a stall with two stack entries
    do_call(8'h20);
    do_call(8'h30);
    check("pre_rst_op_pc", bus.op_pc, 8'h30);
    bus.stall = 1'b1;
    tick();
    check("pre_rst_hold", bus.rom_addr, 8'h31);
    rst = 1'b1;
    tick();
    check("mid_rst_rom_addr", bus.rom_addr, 8'h00);
    check("mid_rst_valid", bus.valid, 1'b0);
    check("mid_rst_err", bus.stack_err, 1'b0);
    check("mid_rst_op_pc", bus.op_pc, 8'h00);
    rst = 1'b0; bus.stall = 1'b0;
    tick();
    check("post_rst_opcode", bus.opcode, 16'h0100);
    check("post_rst_valid", bus.valid, 1'b1);
    bus.ret = 1'b1;
    tick();
    bus.ret = 1'b0;
    check("empty_ret_err", bus.stack_err, 1'b1);
    check("empty_ret_rom_addr", bus.rom_addr, 8'h00);
    tick();
    check("empty_ret_op_pc", bus.op_pc, 8'h00);
    check("empty_ret_valid", bus.valid, 1'b1);

    // call + ret together: ret wins, no jump to the call target
    bus.call = 1'b1; bus.ret = 1'b1; bus.br_target = 8'h50;
    tick();
    bus.call = 1'b0; bus.ret = 1'b0;
    check("call_ret_rom_addr", bus.rom_addr, 8'h00);
    check("call_ret_bubble", bus.valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
